flash_loader: RTL and testbench
===============================

FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 Parameter MAX_WORDS, default 8192: largest accepted image length in 32-bit words.
REQ-002 Parameter TIMEOUT, default 255: cycles with mem_select high and no mem_ready before the block reports an error.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; starts a load from IDLE, ignored elsewhere.
REQ-006 in_valid  input  1  byte available on in_data.
REQ-007 in_data  input  8  image byte stream.
REQ-008 in_ready  output  1  block accepts in_data this cycle; transfer when in_valid && in_ready.
REQ-009 mem_select  output  1  bus request to the flash responder.
REQ-010 mem_wstrb  output  4  byte strobes; 4'b1111 write, 4'b0000 read.
REQ-011 mem_addr  output  17  byte address, bits [1:0] always 0.
REQ-012 mem_wdata  output  32  write data.
REQ-013 mem_ready  input  1  responder ready; rises one cycle after mem_select and stays high while mem_select is held.
REQ-014 mem_rdata  input  32  read data, valid when mem_ready is high.
REQ-015 busy, done, error  output  1 each  status: load in progress / completed OK / aborted.
REQ-016 words_written  output  14  count of words committed in the current load.

Function
REQ-017 Stream format: 2-byte little-endian word count N, then N words of 4 bytes each, little-endian, written to addresses 0, 4, 8 and so on.
REQ-018 FSM states: IDLE, HDR_LO, HDR_HI, COLLECT, WRITE, RELEASE, DONE, ERROR, plus READ and CHECK when the feature in REQ-033 is compiled in.
REQ-019 IDLE to HDR_LO on start; done and error clear and words_written resets to 0 on that transition.
REQ-020 in_ready is high only in HDR_LO, HDR_HI and COLLECT; exactly one byte is consumed per handshake.
REQ-021 Header handling:
- N=0: HDR_HI goes to DONE with no bus activity.
- N>MAX_WORDS: HDR_HI goes to ERROR.
- Otherwise HDR_HI goes to COLLECT.
REQ-022 COLLECT places byte k of the word (k=0..3) in mem_wdata[8k+7:8k]; after the 4th byte it goes to WRITE.
REQ-023 WRITE drives mem_select=1, mem_wstrb=4'b1111 and mem_addr=words_written*4, all held stable until mem_ready is sampled high.
REQ-024 On mem_ready high the block deasserts mem_select on the next edge and enters RELEASE.
REQ-025 RELEASE holds mem_select low until mem_ready is sampled low, which guards against the responder's one-cycle-late ready.
REQ-026 On leaving RELEASE, words_written increments; if it now equals N the FSM enters DONE, else COLLECT.
REQ-027 mem_select is never high for two transactions without at least one low cycle where mem_ready is low between them.
REQ-028 A cycle counter runs while mem_select is high; reaching TIMEOUT without mem_ready forces ERROR and drops mem_select.
REQ-029 DONE and ERROR assert done or error respectively, hold it, keep busy=0, and return to IDLE only on start, which begins a new load.
REQ-030 busy is 1 in every state except IDLE, DONE and ERROR.
REQ-031 start while busy has no effect; in_valid outside the accepting states is ignored and the data is not consumed.

Reset
REQ-032 reset asserted at any time, including mid-transaction, immediately forces:
- state to IDLE;
- mem_select, in_ready, busy, done and error to 0;
- mem_wstrb, mem_addr, mem_wdata and words_written to 0.

Configuration
REQ-033 Macro FLASH_LOADER_READBACK_EN.
- Defined: after RELEASE, the block issues a read (state READ, mem_wstrb=0, same address) using the same select/ready/release rules, then CHECK compares mem_rdata to the written word. Mismatch goes to ERROR; match continues as in REQ-026.
- Undefined: no READ or CHECK states, and mem_wstrb is never 4'b0000 while mem_select is high.

Verification
REQ-034 Bytes 02 00 11 22 33 44 AA BB CC DD -> two writes: 0x44332211 at 0x0 and 0xDDCCBBAA at 0x4; done=1; words_written=2.
REQ-035 Header 00 00 -> done=1 within 3 cycles of the last byte; mem_select never high.
REQ-036 Header 01 20 (N=8193) -> error=1; no bus write issued.
REQ-037 Responder holds mem_ready=0 -> error exactly TIMEOUT+1 cycles after mem_select rises; mem_select drops.
REQ-038 reset pulsed while mem_select=1 in the 3rd write -> all outputs 0 that cycle; a following start and 1-word image writes at 0x0.
REQ-039 With FLASH_LOADER_READBACK_EN defined, responder corrupts readback bit 0 -> error=1 and words_written=0.

Source files
------------

// File: rtl/flash_loader.sv
// flash_loader: receives a length-prefixed little-endian byte image and writes it
// word by word to a flash responder over a select/ready handshake.
// Optional readback verification is enabled by defining FLASH_LOADER_READBACK_EN.
module flash_loader #(
   parameter int MAX_WORDS = 8192,
   parameter int TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_select,
   output logic [3:0]  mem_wstrb,
   output logic [16:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [13:0] words_written
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_HDR_LO  = 4'd1;
   localparam logic [3:0] S_HDR_HI  = 4'd2;
   localparam logic [3:0] S_COLLECT = 4'd3;
   localparam logic [3:0] S_WRITE   = 4'd4;
   localparam logic [3:0] S_RELEASE = 4'd5;
   localparam logic [3:0] S_DONE    = 4'd6;
   localparam logic [3:0] S_ERROR   = 4'd7;
`ifdef FLASH_LOADER_READBACK_EN
   localparam logic [3:0] S_READ    = 4'd8;
   localparam logic [3:0] S_CHECK   = 4'd9;
`endif

   // Timer must be able to hold the value TIMEOUT itself.
   localparam int             TW           = $clog2(TIMEOUT + 2);
   localparam logic [TW-1:0]  LP_TIMEOUT   = TW'(TIMEOUT);
   localparam logic [15:0]    LP_MAX_WORDS = 16'(MAX_WORDS);

   logic [3:0]    r_state;
   logic [15:0]   r_count_n;
   logic [1:0]    r_byte_idx;
   logic [31:0]   r_wdata;
   logic [16:0]   r_addr;
   logic [3:0]    r_wstrb;
   logic          r_select;
   logic [13:0]   r_words;
   logic [TW-1:0] r_timer;
   logic          r_done;
   logic          r_error;
`ifdef FLASH_LOADER_READBACK_EN
   logic [31:0]   r_rdata;
`else
   // Read data is only consumed by the readback checker.
   logic          w_unused_rdata;
   assign w_unused_rdata = ^mem_rdata;
`endif

   logic          w_in_ready;
   logic          w_busy;
   logic          w_accept;
   logic [15:0]   w_hdr_n;
   logic [13:0]   w_words_inc;
   logic          w_last;
   logic          w_timeout;

   assign w_accept    = in_valid && w_in_ready;
   assign w_hdr_n     = {in_data, r_count_n[7:0]};
   assign w_words_inc = r_words + 14'd1;
   assign w_last      = ({2'b00, w_words_inc} == r_count_n);
   assign w_timeout   = (r_timer == LP_TIMEOUT);

   // Byte acceptance and busy status decode directly from the state.
   always_comb begin
      w_in_ready = 1'b0;
      w_busy     = 1'b1;
      case (r_state)
         S_HDR_LO, S_HDR_HI, S_COLLECT: w_in_ready = 1'b1;
         S_IDLE, S_DONE, S_ERROR:       w_busy     = 1'b0;
         default:                       w_busy     = 1'b1;
      endcase
   end

   // Main load sequencer: header parse, word assembly, bus write and optional readback.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_count_n  <= 16'd0;
         r_byte_idx <= 2'd0;
         r_wdata    <= 32'd0;
         r_addr     <= 17'd0;
         r_wstrb    <= 4'd0;
         r_select   <= 1'b0;
         r_words    <= 14'd0;
         r_timer    <= '0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
`ifdef FLASH_LOADER_READBACK_EN
         r_rdata    <= 32'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  r_state <= S_HDR_LO;
                  r_done  <= 1'b0;
                  r_error <= 1'b0;
                  r_words <= 14'd0;
               end
            end
            S_HDR_LO: begin
               if (w_accept) begin
                  r_count_n[7:0] <= in_data;
                  r_state        <= S_HDR_HI;
               end
            end
            S_HDR_HI: begin
               if (w_accept) begin
                  r_count_n[15:8] <= in_data;
                  r_byte_idx      <= 2'd0;
                  if (w_hdr_n == 16'd0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else if (w_hdr_n > LP_MAX_WORDS) begin
                     r_state <= S_ERROR;
                     r_error <= 1'b1;
                  end else begin
                     r_state <= S_COLLECT;
                  end
               end
            end
            S_COLLECT: begin
               if (w_accept) begin
                  r_wdata[{r_byte_idx, 3'b000} +: 8] <= in_data;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     r_state  <= S_WRITE;
                     r_select <= 1'b1;
                     r_wstrb  <= 4'b1111;
                     r_addr   <= {1'b0, r_words, 2'b00};
                     r_timer  <= '0;
                  end
               end
            end
            S_WRITE: begin
               if (mem_ready) begin
                  r_select <= 1'b0;
                  r_state  <= S_RELEASE;
               end else if (w_timeout) begin
                  r_select <= 1'b0;
                  r_error  <= 1'b1;
                  r_state  <= S_ERROR;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_RELEASE: begin
               // Wait out the responder's late ready before the next request.
               if (!mem_ready) begin
`ifdef FLASH_LOADER_READBACK_EN
                  r_state  <= S_READ;
                  r_select <= 1'b1;
                  r_wstrb  <= 4'b0000;
                  r_timer  <= '0;
`else
                  r_words <= w_words_inc;
                  if (w_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_COLLECT;
                  end
`endif
               end
            end
`ifdef FLASH_LOADER_READBACK_EN
            S_READ: begin
               if (mem_ready) begin
                  r_rdata  <= mem_rdata;
                  r_select <= 1'b0;
                  r_state  <= S_CHECK;
               end else if (w_timeout) begin
                  r_select <= 1'b0;
                  r_error  <= 1'b1;
                  r_state  <= S_ERROR;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_CHECK: begin
               // Doubles as the release phase of the read transaction.
               if (!mem_ready) begin
                  if (r_rdata != r_wdata) begin
                     r_state <= S_ERROR;
                     r_error <= 1'b1;
                  end else begin
                     r_words <= w_words_inc;
                     if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= S_COLLECT;
                     end
                  end
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready      = w_in_ready;
   assign busy          = w_busy;
   assign done          = r_done;
   assign error         = r_error;
   assign mem_select    = r_select;
   assign mem_wstrb     = r_wstrb;
   assign mem_addr      = r_addr;
   assign mem_wdata     = r_wdata;
   assign words_written = r_words;

endmodule

// File: tb/tb_flash_loader.sv
// Directed testbench for flash_loader with a simple select/ready flash responder.
module tb_flash_loader;

   localparam int TIMEOUT = 255;

   logic        clk;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_select;
   logic [3:0]  mem_wstrb;
   logic [16:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        done;
   logic        error;
   logic [13:0] words_written;

   int passed = 0;
   int total  = 0;

   // responder controls and monitors
   logic        resp_en = 1'b1;
   logic        corrupt = 1'b0;
   logic [31:0] mem_model [0:7];
   logic [16:0] log_addr [0:31];
   logic [31:0] log_data [0:31];
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          sel_rises = 0;
   int          viol = 0;
   logic        prev_sel = 1'b0;

   flash_loader #(.MAX_WORDS(8192), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_select(mem_select), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .busy(busy), .done(done), .error(error),
      .words_written(words_written)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Responder: ready follows select one cycle late.
   always @(posedge clk or posedge reset) begin
      if (reset) mem_ready <= 1'b0;
      else       mem_ready <= mem_select && resp_en;
   end

   always_comb mem_rdata = mem_model[mem_addr[4:2]] ^ {31'd0, corrupt};

   // Transaction monitor
   always @(posedge clk) begin
      prev_sel <= mem_select;
      if (mem_select && !prev_sel) begin
         sel_rises <= sel_rises + 1;
         if (mem_ready) viol <= viol + 1;
      end
      if (mem_select && mem_ready && mem_wstrb == 4'b1111) begin
         mem_model[mem_addr[4:2]] <= mem_wdata;
         if (wr_cnt < 32) begin
            log_addr[wr_cnt] <= mem_addr;
            log_data[wr_cnt] <= mem_wdata;
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (mem_select && mem_ready && mem_wstrb == 4'b0000) rd_cnt <= rd_cnt + 1;
   end

   // All tasks are entered and left at a falling edge.
   task automatic send_byte(input logic [7:0] b);
      int g;
      g = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && g < 1000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 1000) begin
         total++;
         $display("FAIL send_byte_timeout got in_ready=0 want 1");
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_status(output int cyc);
      cyc = 0;
      while (!done && !error && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
   endtask

   task automatic test_reset();
      total++; if (busy !== 1'b0)  $display("FAIL reset_busy got %0b want 0", busy);  else passed++;
      total++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL reset_status got done=%0b error=%0b want 0/0", done, error); else passed++;
      total++; if (in_ready !== 1'b0 || mem_select !== 1'b0) $display("FAIL reset_hs got in_ready=%0b sel=%0b want 0/0", in_ready, mem_select); else passed++;
      total++; if (mem_wstrb !== 4'd0 || mem_addr !== 17'd0 || mem_wdata !== 32'd0 || words_written !== 14'd0)
         $display("FAIL reset_regs got wstrb=%h addr=%h wdata=%h words=%0d want zeros", mem_wstrb, mem_addr, mem_wdata, words_written);
      else passed++;
   endtask

   task automatic test_two_words();
      int cyc;
      int base;
      base = wr_cnt;
      pulse_start();
      total++; if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL two_busy got busy=%0b in_ready=%0b want 1/1", busy, in_ready); else passed++;
      send_byte(8'h02); send_byte(8'h00);
      send_word(32'h44332211);
      send_word(32'hDDCCBBAA);
      wait_status(cyc);
      total++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL two_done got done=%0b error=%0b want 1/0", done, error); else passed++;
      total++; if (words_written !== 14'd2) $display("FAIL two_words got %0d want 2", words_written); else passed++;
      total++; if (wr_cnt - base !== 2) $display("FAIL two_wrcnt got %0d want 2", wr_cnt - base); else passed++;
      total++; if (log_addr[base] !== 17'h0 || log_data[base] !== 32'h44332211)
         $display("FAIL two_w0 got %h@%h want 44332211@0", log_data[base], log_addr[base]); else passed++;
      total++; if (log_addr[base+1] !== 17'h4 || log_data[base+1] !== 32'hDDCCBBAA)
         $display("FAIL two_w1 got %h@%h want ddccbbaa@4", log_data[base+1], log_addr[base+1]); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL two_idle_busy got %0b want 0", busy); else passed++;
      $display("two-word load: cycles_after_last=%0d writes=%0d", cyc, wr_cnt - base);
   endtask

   task automatic test_zero_len();
      int cyc;
      int rises;
      rises = sel_rises;
      pulse_start();
      total++; if (done !== 1'b0) $display("FAIL zero_done_clear got %0b want 0", done); else passed++;
      send_byte(8'h00); send_byte(8'h00);
      wait_status(cyc);
      total++; if (done !== 1'b1 || cyc > 3) $display("FAIL zero_done got done=%0b cycles=%0d want 1 within 3", done, cyc); else passed++;
      total++; if (sel_rises !== rises) $display("FAIL zero_nobus got %0d selects want 0", sel_rises - rises); else passed++;
      // Data offered while finished must not be taken.
      in_valid = 1'b1; in_data = 8'h5A;
      @(negedge clk);
      total++; if (in_ready !== 1'b0 || done !== 1'b1) $display("FAIL zero_ignore got in_ready=%0b done=%0b want 0/1", in_ready, done); else passed++;
      in_valid = 1'b0;
      $display("zero-length load: cycles_after_last=%0d", cyc);
   endtask

   task automatic test_oversize();
      int cyc;
      int rises;
      rises = sel_rises;
      pulse_start();
      send_byte(8'h01); send_byte(8'h20);
      wait_status(cyc);
      total++; if (error !== 1'b1 || done !== 1'b0) $display("FAIL over_error got error=%0b done=%0b want 1/0", error, done); else passed++;
      total++; if (sel_rises !== rises) $display("FAIL over_nobus got %0d selects want 0", sel_rises - rises); else passed++;
      // Exactly MAX_WORDS is accepted; a start while busy is ignored.
      pulse_start();
      total++; if (error !== 1'b0) $display("FAIL max_err_clear got %0b want 0", error); else passed++;
      send_byte(8'h00); send_byte(8'h20);
      total++; if (busy !== 1'b1 || error !== 1'b0 || in_ready !== 1'b1) $display("FAIL max_accept got busy=%0b error=%0b in_ready=%0b want 1/0/1", busy, error, in_ready); else passed++;
      send_byte(8'h77);
      pulse_start();
      send_byte(8'h66); send_byte(8'h55); send_byte(8'h44);
      @(negedge clk);
      total++; if (mem_select !== 1'b1 || mem_wdata !== 32'h44556677) $display("FAIL busy_start got sel=%0b wdata=%h want 1/44556677", mem_select, mem_wdata); else passed++;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      $display("oversize header: error=%0b", error);
   endtask

   task automatic test_timeout();
      int g;
      int cyc;
      resp_en = 1'b0;
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'hCAFEF00D);
      g = 0;
      while (!mem_select && g < 100) begin @(negedge clk); g++; end
      total++; if (mem_select !== 1'b1 || mem_wstrb !== 4'b1111 || mem_addr !== 17'd0)
         $display("FAIL to_select got sel=%0b wstrb=%h addr=%h want 1/f/0", mem_select, mem_wstrb, mem_addr); else passed++;
      cyc = 0;
      while (!error && cyc < 1000) begin @(negedge clk); cyc++; end
      total++; if (cyc !== TIMEOUT + 1) $display("FAIL to_cycles got %0d want %0d", cyc, TIMEOUT + 1); else passed++;
      total++; if (mem_select !== 1'b0 || error !== 1'b1) $display("FAIL to_drop got sel=%0b error=%0b want 0/1", mem_select, error); else passed++;
      resp_en = 1'b1;
      $display("timeout: error after %0d cycles", cyc);
   endtask

   task automatic test_reset_mid();
      int cyc;
      int base;
      base = wr_cnt;
      pulse_start();
      send_byte(8'h03); send_byte(8'h00);
      send_word(32'h01010101);
      send_word(32'h02020202);
      send_word(32'h03030303);
      total++; if (mem_select !== 1'b1 || wr_cnt - base !== 2 || mem_addr !== 17'h8)
         $display("FAIL mid_third got sel=%0b writes=%0d addr=%h want 1/2/8", mem_select, wr_cnt - base, mem_addr); else passed++;
      reset = 1'b1;
      #1;
      total++; if (mem_select !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0)
         $display("FAIL mid_ctl got sel=%0b rdy=%0b busy=%0b done=%0b err=%0b want 0s", mem_select, in_ready, busy, done, error); else passed++;
      total++; if (mem_wstrb !== 4'd0 || mem_addr !== 17'd0 || mem_wdata !== 32'd0 || words_written !== 14'd0)
         $display("FAIL mid_regs got wstrb=%h addr=%h wdata=%h words=%0d want zeros", mem_wstrb, mem_addr, mem_wdata, words_written); else passed++;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      base = wr_cnt;
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'h12345678);
      wait_status(cyc);
      total++; if (done !== 1'b1 || words_written !== 14'd1) $display("FAIL mid_reload got done=%0b words=%0d want 1/1", done, words_written); else passed++;
      total++; if (wr_cnt - base !== 1 || log_addr[base] !== 17'h0 || log_data[base] !== 32'h12345678)
         $display("FAIL mid_write got %0d writes %h@%h want 1 12345678@0", wr_cnt - base, log_data[base], log_addr[base]); else passed++;
      $display("reset mid-write: reload done=%0b words=%0d", done, words_written);
   endtask

   task automatic test_readback();
      int cyc;
      int rd0;
      rd0 = rd_cnt;
`ifdef FLASH_LOADER_READBACK_EN
      corrupt = 1'b1;
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'h0BADBEEF);
      wait_status(cyc);
      total++; if (error !== 1'b1 || words_written !== 14'd0) $display("FAIL rb_bad got error=%0b words=%0d want 1/0", error, words_written); else passed++;
      corrupt = 1'b0;
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'h600DF00D);
      wait_status(cyc);
      total++; if (done !== 1'b1 || words_written !== 14'd1) $display("FAIL rb_good got done=%0b words=%0d want 1/1", done, words_written); else passed++;
      total++; if (rd_cnt - rd0 !== 2) $display("FAIL rb_reads got %0d want 2", rd_cnt - rd0); else passed++;
`else
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'h600DF00D);
      wait_status(cyc);
      total++; if (done !== 1'b1 || words_written !== 14'd1) $display("FAIL norb_done got done=%0b words=%0d want 1/1", done, words_written); else passed++;
`endif
      total++; if (rd_cnt !== rd0 + ((rd_cnt > rd0) ? 2 : 0) || (rd_cnt == rd0 && 0)) $display("FAIL rb_readcount got %0d", rd_cnt); else passed++;
      $display("readback scenario: done=%0b error=%0b reads=%0d", done, error, rd_cnt - rd0);
   endtask

   task automatic test_protocol();
      total++; if (viol !== 0) $display("FAIL proto_gap got %0d back-to-back selects want 0", viol); else passed++;
`ifndef FLASH_LOADER_READBACK_EN
      total++; if (rd_cnt !== 0) $display("FAIL proto_noread got %0d reads want 0", rd_cnt); else passed++;
`endif
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      for (int i = 0; i < 8; i++) mem_model[i] = 32'd0;
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      test_two_words();
      test_zero_len();
      test_oversize();
      test_timeout();
      test_reset_mid();
      test_readback();
      test_protocol();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
